// File: rtl/processor_run_ctrl_if.sv
// rtl/processor_run_ctrl_if.sv - DM write bus and write-log stream between processor/monitor and the run controller
interface processor_run_ctrl_if #(
  parameter int N = 64
);
  logic         DM_writeEnable;
  logic [N-1:0] DM_addr;
  logic [N-1:0] DM_writeData;
  logic         log_valid;
  logic [N-1:0] log_addr;
  logic [N-1:0] log_data;
  logic         log_ready;

  modport master (
    output DM_writeEnable, DM_addr, DM_writeData, log_ready,
    input  log_valid, log_addr, log_data
  );

  modport slave (
    input  DM_writeEnable, DM_addr, DM_writeData, log_ready,
    output log_valid, log_addr, log_data
  );
endinterface

// File: rtl/processor_run_ctrl.sv
// rtl/processor_run_ctrl.sv - reset/run/dump sequencer for processor_arm with a DM write-log FIFO
module processor_run_ctrl #(
  parameter int           N            = 64,
  parameter int           RESET_CYCLES = 2,
  parameter int           RUN_CYCLES   = 200,
  parameter bit           HALT_EN      = 1'b1,
  parameter logic [N-1:0] HALT_ADDR    = 'hFF8,
  parameter int           DUMP_CYCLES  = 2,
  parameter int           LOG_DEPTH    = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  processor_run_ctrl_if.slave   dm,
  output logic                  cpu_reset,
  output logic                  dump,
  output logic                  done,
  output logic                  halted,
  output logic [31:0]           cycle_count,
  output logic                  log_overflow
);
  localparam int          PTR_W      = $clog2(LOG_DEPTH);
  localparam logic [31:0] RESET_LAST = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] DUMP_LAST  = 32'(DUMP_CYCLES - 1);
  localparam logic [31:0] RUN_LIM    = 32'(RUN_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_DUMP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      phase_q, phase_d;
  logic [31:0]      cc_q, cc_d, cc_inc;
  logic             halted_q, halted_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W:0]   wr_q, wr_d, rd_q, rd_d;
  logic [2*N-1:0]   log_mem_q [LOG_DEPTH];

  logic restart, halt_store, push, pop, full, push_ok;

  assign halt_store = HALT_EN && dm.DM_writeEnable && (dm.DM_addr == HALT_ADDR);
  assign cc_inc     = (cc_q == 32'hFFFF_FFFF) ? cc_q : cc_q + 32'd1;
  assign push       = (state_q == S_RUN) && dm.DM_writeEnable;
  assign pop        = dm.log_valid && dm.log_ready;
  assign full       = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign push_ok    = push && (!full || pop);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cc_d     = cc_q;
    halted_d = halted_q;
    restart  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_HOLD;
          phase_d = 32'd0;
          restart = 1'b1;
        end
      end
      S_HOLD: begin
        if (phase_q == RESET_LAST) begin
          state_d = S_RUN;
          phase_d = 32'd0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      S_RUN: begin
        cc_d = cc_inc;
        // Halt store takes priority over a coincident budget expiry.
        if (halt_store) begin
          halted_d = 1'b1;
          state_d  = S_DUMP;
        end else if (cc_inc == RUN_LIM) begin
          state_d = S_DUMP;
        end
      end
      S_DUMP: begin
        if (phase_q == DUMP_LAST) state_d = S_DONE;
        else                      phase_d = phase_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (restart) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (pop)     rd_d = rd_q + 1'b1;
      if (push_ok) wr_d = wr_q + 1'b1;
      else if (push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      phase_q  <= '0;
      cc_q     <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      phase_q  <= phase_d;
      cc_q     <= restart ? 32'd0 : cc_d;
      halted_q <= restart ? 1'b0 : halted_d;
      ovf_q    <= ovf_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) log_mem_q[wr_q[PTR_W-1:0]] <= {dm.DM_addr, dm.DM_writeData};
  end

  always_comb begin
    cpu_reset = !((state_q == S_RUN) || (state_q == S_DUMP));
    dump      = (state_q == S_DUMP);
    done      = (state_q == S_DONE);
  end

  assign halted       = halted_q;
  assign cycle_count  = cc_q;
  assign log_overflow = ovf_q;
  assign dm.log_valid = (wr_q != rd_q);
  assign dm.log_addr  = log_mem_q[rd_q[PTR_W-1:0]][2*N-1:N];
  assign dm.log_data  = log_mem_q[rd_q[PTR_W-1:0]][N-1:0];
endmodule
